halt_dump_ctrl: RTL and testbench

HALT_DUMP_CTRL -- requirements
Module: halt_dump_ctrl

---
 rtl/halt_dump_ctrl.sv | 161 ++++++++++++++++
 tb/tb_halt_dump_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/halt_dump_ctrl.sv
// Halt-detect and memory-dump controller: watches per-core instruction streams for a
// zero (halt) word, lets the pipeline drain, then streams dmem out over a ready/valid port.
module halt_dump_ctrl #(
    parameter int NUM_CORES       = 4,
    parameter int INST_WIDTH      = 32,
    parameter int DATA_WIDTH      = 64,
    parameter int MEM_DEPTH       = 128,
    parameter int DRAIN_CYCLES    = 8,
    parameter int WATCHDOG_CYCLES = 25000
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [NUM_CORES*INST_WIDTH-1:0] inst_in,
    output logic                            mem_en,
    output logic [7:0]                      mem_addr,
    input  logic [DATA_WIDTH-1:0]           mem_data,
    output logic                            dump_valid,
    input  logic                            dump_ready,
    output logic [7:0]                      dump_addr,
    output logic [DATA_WIDTH-1:0]           dump_data,
    output logic [NUM_CORES-1:0]            halted,
    output logic                            busy,
    output logic                            done,
    output logic                            timed_out
);

    localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, DUMP, DONE} state_t;

    state_t                  state_reg, state_next;
    logic                    start_run;
    logic [NUM_CORES-1:0]    zero_vec;
    logic [NUM_CORES-1:0]    halted_seen;
    logic [NUM_CORES-1:0]    halted_reg;
    logic                    timed_out_reg;
    logic [WD_W-1:0]         wd_cnt_reg;
    logic [7:0]              drain_cnt_reg;
    logic [8:0]              rd_idx_reg;
    logic [7:0]              pend_addr_reg;
    logic                    rd_pend_reg;
    logic                    dump_valid_reg;
    logic [7:0]              dump_addr_reg;
    logic [DATA_WIDTH-1:0]   dump_data_reg;
    logic                    wd_expire;
    logic                    drain_last;
    logic                    handshake;
    logic                    last_hs;
    logic                    issue;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CORES; gi++) begin : g_zero
            assign zero_vec[gi] = (inst_in[gi*INST_WIDTH +: INST_WIDTH] == '0);
        end
    endgenerate

    // The halt seen this very cycle counts toward the all-halted test.
    assign halted_seen = halted_reg | zero_vec;
    assign wd_expire   = (wd_cnt_reg == WD_W'(WATCHDOG_CYCLES - 1));
    assign drain_last  = (drain_cnt_reg == 8'(DRAIN_CYCLES - 1));
    assign handshake   = dump_valid_reg && dump_ready;
    assign last_hs     = handshake && (dump_addr_reg == 8'(MEM_DEPTH - 1));

    // A read may be launched in the same cycle the held word is taken, giving one word per 2 cycles.
    assign issue = (state_reg == DUMP) && !rd_pend_reg && (rd_idx_reg < 9'(MEM_DEPTH))
                   && (!dump_valid_reg || dump_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        start_run  = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next = RUN;
                    start_run  = 1'b1;
                end
            end
            RUN: begin
                if (wd_expire)          state_next = DUMP;
                else if (&halted_seen)  state_next = DRAIN;
            end
            DRAIN: begin
                if (wd_expire || drain_last) state_next = DUMP;
            end
            DUMP: begin
                if (last_hs) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halted_reg     <= '0;
            timed_out_reg  <= 1'b0;
            wd_cnt_reg     <= '0;
            drain_cnt_reg  <= '0;
            rd_idx_reg     <= '0;
            pend_addr_reg  <= '0;
            rd_pend_reg    <= 1'b0;
            dump_valid_reg <= 1'b0;
            dump_addr_reg  <= '0;
            dump_data_reg  <= '0;
        end else if (start_run) begin
            halted_reg     <= '0;
            timed_out_reg  <= 1'b0;
            wd_cnt_reg     <= '0;
            drain_cnt_reg  <= '0;
            rd_idx_reg     <= '0;
            pend_addr_reg  <= '0;
            rd_pend_reg    <= 1'b0;
            dump_valid_reg <= 1'b0;
            dump_addr_reg  <= '0;
            dump_data_reg  <= '0;
        end else begin
            if (state_reg == RUN) begin
                halted_reg <= halted_seen;
            end
            if (state_reg == RUN || state_reg == DRAIN) begin
                wd_cnt_reg <= wd_cnt_reg + 1'b1;
                if (wd_expire) timed_out_reg <= 1'b1;
            end
            if (state_reg == DRAIN) begin
                drain_cnt_reg <= drain_cnt_reg + 1'b1;
            end
            rd_pend_reg <= issue;
            if (issue) begin
                rd_idx_reg    <= rd_idx_reg + 1'b1;
                pend_addr_reg <= rd_idx_reg[7:0];
            end
            if (rd_pend_reg) begin
                dump_valid_reg <= 1'b1;
                dump_addr_reg  <= pend_addr_reg;
                dump_data_reg  <= mem_data;
            end else if (handshake) begin
                dump_valid_reg <= 1'b0;
            end
        end
    end

    assign mem_en     = issue;
    assign mem_addr   = issue ? rd_idx_reg[7:0] : 8'd0;
    assign dump_valid = dump_valid_reg;
    assign dump_addr  = dump_addr_reg;
    assign dump_data  = dump_data_reg;
    assign halted     = halted_reg;
    assign timed_out  = timed_out_reg;
    assign busy       = (state_reg == RUN) || (state_reg == DRAIN) || (state_reg == DUMP);
    assign done       = (state_reg == DONE);

endmodule

// File: tb/tb_halt_dump_ctrl.sv
// Randomized bench for halt_dump_ctrl: a cycle-level reference derived from halt times,
// drain length and watchdog limit predicts dump timing, addresses, data and final flags.
module tb_halt_dump_ctrl;

    localparam int NC = 4;
    localparam int IW = 32;
    localparam int DW = 64;
    localparam int MD = 128;
    localparam int DC = 8;
    localparam int WD = 100;

    logic              clk;
    logic              reset;
    logic              start;
    logic [NC*IW-1:0]  inst_in;
    logic              mem_en;
    logic [7:0]        mem_addr;
    logic [DW-1:0]     mem_data;
    logic              dump_valid;
    logic              dump_ready;
    logic [7:0]        dump_addr;
    logic [DW-1:0]     dump_data;
    logic [NC-1:0]     halted;
    logic              busy;
    logic              done;
    logic              timed_out;

    logic [DW-1:0]     mem [256];
    int                n_tests = 0;
    int                n_fail  = 0;
    int                run_no  = 0;

    halt_dump_ctrl #(
        .NUM_CORES(NC), .INST_WIDTH(IW), .DATA_WIDTH(DW), .MEM_DEPTH(MD),
        .DRAIN_CYCLES(DC), .WATCHDOG_CYCLES(WD)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .inst_in(inst_in),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
        .dump_data(dump_data), .halted(halted), .busy(busy), .done(done),
        .timed_out(timed_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous dmem: data one cycle after the enable.
    always @(posedge clk) begin
        if (mem_en) mem_data <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (run %0d)", tag, got, exp, run_no);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_en"},     mem_en,     0);
        check({tag, "_mem_addr"},   mem_addr,   0);
        check({tag, "_dump_valid"}, dump_valid, 0);
        check({tag, "_dump_addr"},  dump_addr,  0);
        check({tag, "_dump_data"},  dump_data,  0);
        check({tag, "_halted"},     halted,     0);
        check({tag, "_busy"},       busy,       0);
        check({tag, "_done"},       done,       0);
        check({tag, "_timed_out"},  timed_out,  0);
    endtask

    // mode 0: ready high, 1: random ready, 2: hold word 5 for 10 cycles.
    // start_k: extra start pulse at that RUN cycle (0 = none); abort_idx: reset at that word (-1 = none).
    task automatic do_run(input int t0, input int t1, input int t2, input int t3,
                          input int mode, input int start_k, input int abort_idx);
        int t[4];
        int h, ed, k, exp_idx, stall;
        bit exp_to, pv, pr, exp_v;
        logic [NC-1:0] exp_halt;
        t = '{t0, t1, t2, t3};
        run_no++;
        h = 0;
        for (int i = 0; i < NC; i++) if (t[i] > h) h = t[i];
        exp_to = !(h + DC < WD);
        ed     = exp_to ? WD : h + DC;
        for (int i = 0; i < NC; i++) exp_halt[i] = (t[i] <= WD);

        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < NC; i++) inst_in[i*IW +: IW] = $urandom() | 32'h1;
        @(negedge clk);
        start = 1'b0;
        check("start_halted_clr", halted, 0);
        check("start_busy", busy, 1);
        check("start_done_clr", done, 0);
        check("start_to_clr", timed_out, 0);

        for (k = 1; k <= ed; k++) begin
            start = (k == start_k);
            for (int i = 0; i < NC; i++)
                inst_in[i*IW +: IW] = (k == t[i]) ? 32'd0 : ($urandom() | 32'h1);
            @(negedge clk);
            start = 1'b0;
            check("run_mem_en", mem_en, (k == ed));
            check("run_timed_out", timed_out, (exp_to && k == ed));
            if (k == ed) check("dump_first_addr", mem_addr, 0);
        end
        k = ed;

        exp_idx = 0;
        stall = 0;
        dump_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        pv = dump_valid;
        pr = dump_ready;
        while (exp_idx < MD && k < ed + 3000) begin
            @(negedge clk);
            k++;
            if (pv && pr) exp_idx++;
            if (exp_idx == MD) break;
            if (abort_idx >= 0 && dump_valid && exp_idx == abort_idx) begin
                reset = 1'b0;
                #1;
                check_all_zero("abort");
                @(negedge clk);
                reset = 1'b1;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    check("post_abort_valid", dump_valid, 0);
                end
                $display("[TB] run %0d: aborted at word %0d", run_no, exp_idx);
                return;
            end
            if (pv && !pr) check("hold_valid", dump_valid, 1);
            if (mode == 0) begin
                exp_v = (k - ed >= 2) && ((k - ed) % 2 == 0);
                check("tput_valid", dump_valid, exp_v);
            end
            if (dump_valid) begin
                check("dump_addr", dump_addr, exp_idx);
                check("dump_data", dump_data, mem[exp_idx]);
            end
            if (mem_en) check("mem_addr", mem_addr, exp_idx + int'(dump_valid));
            if (dump_valid && !dump_ready) check("stall_mem_en", mem_en, 0);
            if (mode == 0) dump_ready = 1'b1;
            else if (mode == 1) dump_ready = 1'($urandom_range(0, 1));
            else if (dump_valid && exp_idx == 5 && stall < 10) begin
                dump_ready = 1'b0;
                stall++;
            end else dump_ready = 1'b1;
            pv = dump_valid;
            pr = dump_ready;
        end
        if (exp_idx < MD) begin
            check("dump_timeout", exp_idx, MD);
            return;
        end
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("end_timed_out", timed_out, exp_to);
        check("end_halted", halted, exp_halt);
        check("end_valid", dump_valid, 0);
        check("end_mem_en", mem_en, 0);
        if (mode == 0) check("dump_cycles", k - ed, 257);
        if (mode == 2) check("stall_seen", stall, 10);
        $display("[TB] run %0d: t=%0d,%0d,%0d,%0d dump_at=%0d timed_out=%0b words=%0d",
                 run_no, t0, t1, t2, t3, ed, exp_to, exp_idx);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {$urandom(), $urandom()};
        reset = 1'b0;
        start = 1'b0;
        dump_ready = 1'b0;
        inst_in = '0;
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        reset = 1'b1;

        do_run(5, 9, 12, 20, 0, 0, -1);          // nominal halt sequence
        do_run(3, 7, 1000, 50, 1, 0, -1);        // core 2 never halts: watchdog
        do_run(14, 2, 33, 8, 2, 3, -1);          // stalled word 5, start ignored in RUN
        do_run(92, 10, 30, 5, 0, 0, -1);         // drain end collides with watchdog
        do_run(91, 10, 30, 5, 0, 0, -1);         // one cycle earlier: no timeout
        do_run(4, 6, 8, 10, 1, 0, 40);           // reset during dump at word 40
        do_run(6, 4, 2, 11, 0, 0, -1);           // restart from IDLE begins at address 0
        for (int r = 0; r < 3; r++)
            do_run($urandom_range(1, 110), $urandom_range(1, 110),
                   $urandom_range(1, 110), $urandom_range(1, 110),
                   int'($urandom_range(0, 1)), 0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
